// File: rtl/exception_sequencer_pkg.sv
// Shared definitions for the exception sequencer: FSM states, exception codes and the
// memory-address mux select values also used by the control unit and the mux itself.
package exception_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSaveEpc,
    StWait,
    StLoadPc,
    StDone
  } exc_state_e;

  typedef enum logic [1:0] {
    ExcNone     = 2'b00,
    ExcOpcode   = 2'b01,
    ExcOverflow = 2'b10,
    ExcDivzero  = 2'b11
  } exc_code_e;

  typedef enum logic [2:0] {
    MaRegA   = 3'b000,
    MaRegB   = 3'b001,
    MaPc     = 3'b010,
    MaV253   = 3'b011,
    MaV255   = 3'b100,
    MaV254   = 3'b101,
    MaAluOut = 3'b110
  } mem_addr_ctrl_e;

  // Opcode beats overflow beats divide-by-zero; only the winner is handled.
  function automatic exc_code_e exc_prio(input logic opcode, input logic overflow,
                                         input logic divzero);
    if (opcode) begin
      return ExcOpcode;
    end else if (overflow) begin
      return ExcOverflow;
    end else if (divzero) begin
      return ExcDivzero;
    end
    return ExcNone;
  endfunction

  function automatic mem_addr_ctrl_e exc_vector(input exc_code_e code);
    case (code)
      ExcOpcode:   return MaV253;
      ExcOverflow: return MaV254;
      ExcDivzero:  return MaV255;
      default:     return MaRegA;
    endcase
  endfunction

endpackage

// File: rtl/exception_sequencer_mem_wait_counter.sv
// Memory-latency wait counter: loads MemLat-1 at exception entry, counts down to zero.
module exception_sequencer_mem_wait_counter #(
  parameter int unsigned MemLat = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int unsigned CntW = (MemLat > 1) ? $clog2(MemLat) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(MemLat - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/exception_sequencer.sv
// Multicycle-CPU exception entry sequencer: saves EPC, fetches the vector byte through the
// memory-address mux, waits out memory latency and loads PC with the vector.
module exception_sequencer
  import exception_sequencer_pkg::*;
#(
  parameter int unsigned MemLat   = 2,
  parameter int unsigned PcAdjust = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        exc_opcode_i,
  input  logic        exc_overflow_i,
  input  logic        exc_divzero_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] mem_rdata_i,
  output logic [2:0]  mem_addr_ctrl_o,
  output logic        mem_wr_o,
  output logic        epc_wr_o,
  output logic [31:0] epc_data_o,
  output logic        pc_wr_o,
  output logic [31:0] pc_data_o,
  output logic        exc_active_o,
  output logic [1:0]  exc_code_o,
  output logic        exc_done_o
);

  exc_state_e     state_q;
  exc_code_e      code_q;
  mem_addr_ctrl_e ctrl_q;
  logic           epc_wr_q, pc_wr_q, active_q, done_q;
  logic [31:0]    epc_data_q, pc_data_q;

  logic      exc_any, cnt_zero;
  exc_code_e exc_win;

  assign exc_any = exc_opcode_i | exc_overflow_i | exc_divzero_i;
  assign exc_win = exc_prio(exc_opcode_i, exc_overflow_i, exc_divzero_i);

  exception_sequencer_mem_wait_counter #(
    .MemLat(MemLat)
  ) u_mem_wait_counter (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .load_i((state_q == StIdle) && exc_any),
    .dec_i ((state_q == StSaveEpc) || (state_q == StWait)),
    .zero_o(cnt_zero)
  );

  // All outputs are registered alongside the state so each is valid for the whole state cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      code_q     <= ExcNone;
      ctrl_q     <= MaRegA;
      epc_wr_q   <= 1'b0;
      epc_data_q <= '0;
      pc_wr_q    <= 1'b0;
      pc_data_q  <= '0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (exc_any) begin
            state_q    <= StSaveEpc;
            code_q     <= exc_win;
            ctrl_q     <= exc_vector(exc_win);
            active_q   <= 1'b1;
            epc_wr_q   <= 1'b1;
            epc_data_q <= pc_i - 32'(PcAdjust);
          end
        end
        StSaveEpc: begin
          epc_wr_q   <= 1'b0;
          epc_data_q <= '0;
          if (MemLat == 1) begin
            state_q   <= StLoadPc;
            pc_wr_q   <= 1'b1;
            pc_data_q <= {24'b0, mem_rdata_i[7:0]};
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_zero) begin
            state_q   <= StLoadPc;
            pc_wr_q   <= 1'b1;
            pc_data_q <= {24'b0, mem_rdata_i[7:0]};
          end
        end
        StLoadPc: begin
          state_q   <= StDone;
          pc_wr_q   <= 1'b0;
          pc_data_q <= '0;
          ctrl_q    <= MaRegA;
          done_q    <= 1'b1;
        end
        StDone: begin
          state_q  <= StIdle;
          done_q   <= 1'b0;
          active_q <= 1'b0;
          code_q   <= ExcNone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Only the vector byte of the read data is meaningful.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata_i[31:8];

  assign mem_addr_ctrl_o = ctrl_q;
  assign mem_wr_o        = 1'b0;
  assign epc_wr_o        = epc_wr_q;
  assign epc_data_o      = epc_data_q;
  assign pc_wr_o         = pc_wr_q;
  assign pc_data_o       = pc_data_q;
  assign exc_active_o    = active_q;
  assign exc_code_o      = code_q;
  assign exc_done_o      = done_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Bench for exception_sequencer: directed scenarios then random events, two builds (latency 2
// and 1) checked every cycle against a per-exception timeline model.
module tb_exception_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_op, exc_ov, exc_dz;
  logic [31:0] pc_in, rdata;

  logic [2:0]  ctrl     [2];
  logic        mem_wr   [2];
  logic        epc_wr   [2];
  logic [31:0] epc_data [2];
  logic        pc_wr    [2];
  logic [31:0] pc_data  [2];
  logic        active   [2];
  logic [1:0]  code     [2];
  logic        done     [2];

  int compared   = 0;
  int mismatched = 0;

  // Model state per build: offset into the exception timeline (0 = idle).
  int          lat    [2] = '{2, 1};
  int          off    [2];
  logic [1:0]  m_code [2];
  logic [31:0] m_pc   [2];
  logic [7:0]  m_byte [2];

  always #5 clk = ~clk;

  exception_sequencer #(.MemLat(2), .PcAdjust(4)) u_dut_lat2 (
    .clk_i(clk), .rst_ni(rst_n), .exc_opcode_i(exc_op), .exc_overflow_i(exc_ov),
    .exc_divzero_i(exc_dz), .pc_i(pc_in), .mem_rdata_i(rdata),
    .mem_addr_ctrl_o(ctrl[0]), .mem_wr_o(mem_wr[0]), .epc_wr_o(epc_wr[0]),
    .epc_data_o(epc_data[0]), .pc_wr_o(pc_wr[0]), .pc_data_o(pc_data[0]),
    .exc_active_o(active[0]), .exc_code_o(code[0]), .exc_done_o(done[0])
  );

  exception_sequencer #(.MemLat(1), .PcAdjust(4)) u_dut_lat1 (
    .clk_i(clk), .rst_ni(rst_n), .exc_opcode_i(exc_op), .exc_overflow_i(exc_ov),
    .exc_divzero_i(exc_dz), .pc_i(pc_in), .mem_rdata_i(rdata),
    .mem_addr_ctrl_o(ctrl[1]), .mem_wr_o(mem_wr[1]), .epc_wr_o(epc_wr[1]),
    .epc_data_o(epc_data[1]), .pc_wr_o(pc_wr[1]), .pc_data_o(pc_data[1]),
    .exc_active_o(active[1]), .exc_code_o(code[1]), .exc_done_o(done[1])
  );

  function automatic logic [2:0] vec_of(input logic [1:0] c);
    case (c)
      2'b01:   return 3'b011;
      2'b10:   return 3'b101;
      2'b11:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s (MEM_LAT=%0d, t=%0t) observed=%h expected=%h", tag, lat[k], $time,
             obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int   o;
      logic busy;
      o    = off[k];
      busy = (o != 0);
      chk("exc_active", k, 32'(active[k]), 32'(busy));
      chk("exc_code", k, 32'(code[k]), busy ? 32'(m_code[k]) : 32'd0);
      chk("mem_wr", k, 32'(mem_wr[k]), 32'd0);
      chk("epc_wr", k, 32'(epc_wr[k]), 32'(o == 1));
      chk("epc_data", k, epc_data[k], (o == 1) ? m_pc[k] - 32'd4 : 32'd0);
      chk("mem_addr_ctrl", k, 32'(ctrl[k]),
          (o >= 1 && o <= lat[k] + 1) ? 32'(vec_of(m_code[k])) : 32'd0);
      chk("pc_wr", k, 32'(pc_wr[k]), 32'(o == lat[k] + 1));
      chk("pc_data", k, pc_data[k], (o == lat[k] + 1) ? {24'b0, m_byte[k]} : 32'd0);
      chk("exc_done", k, 32'(done[k]), 32'(o == lat[k] + 2));
    end
  endtask

  // Advance each timeline by one rising edge, using the inputs present at that edge.
  task automatic model_edge();
    if (!rst_n) return;
    for (int k = 0; k < 2; k++) begin
      if (off[k] == 0) begin
        if (exc_op || exc_ov || exc_dz) begin
          off[k]    = 1;
          m_code[k] = exc_op ? 2'b01 : (exc_ov ? 2'b10 : 2'b11);
          m_pc[k]   = pc_in;
        end
      end else begin
        if (off[k] == lat[k]) m_byte[k] = rdata[7:0];
        off[k]++;
        if (off[k] > lat[k] + 2) off[k] = 0;
      end
    end
  endtask

  task automatic step(input logic op, input logic ov, input logic dz, input logic [31:0] pc,
                      input logic [31:0] rd);
    exc_op = op;
    exc_ov = ov;
    exc_dz = dz;
    pc_in  = pc;
    rdata  = rd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n  = 1'b0;
    exc_op = 1'b0;
    exc_ov = 1'b0;
    exc_dz = 1'b0;
    pc_in  = '0;
    rdata  = '0;
    off    = '{0, 0};
    m_code = '{2'b00, 2'b00};
    m_pc   = '{32'd0, 32'd0};
    m_byte = '{8'd0, 8'd0};
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Overflow, pc 0x40, vector byte 0x7C.
    step(1'b0, 1'b1, 1'b0, 32'h40, 32'hA5A5A57C);
    chk("t1_epc_data", 0, epc_data[0], 32'h3C);
    chk("t1_ctrl", 0, 32'(ctrl[0]), 32'b101);
    step(1'b0, 1'b0, 1'b0, 32'h1234, 32'hA5A5A57C);
    step(1'b0, 1'b0, 1'b0, 32'h1234, 32'hA5A5A57C);
    chk("t1_pc_data", 0, pc_data[0], 32'h7C);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 32'hA5A5A57C);

    // Opcode and divzero together: opcode wins.
    step(1'b1, 1'b0, 1'b1, 32'h0000_1000, 32'h1111_1111);
    chk("t2_code", 0, 32'(code[0]), 32'b01);
    repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h1111_1122);

    // Divzero at pc 0: EPC wraps, upper read-data bytes ignored.
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FF5A);
    chk("t3_epc_wrap", 0, epc_data[0], 32'hFFFF_FFFC);
    repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FF5A);

    // Second overflow while busy is ignored.
    step(1'b0, 1'b1, 1'b0, 32'h200, 32'h0000_0033);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0033);
    step(1'b0, 1'b1, 1'b0, 32'h300, 32'h0000_0033);
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0033);

    // Reset asserted in WAIT: outputs clear at once, nothing resumes after release.
    step(1'b0, 1'b0, 1'b1, 32'h500, 32'h0000_0044);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0044);
    rst_n = 1'b0;
    #1;
    off = '{0, 0};
    check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0044);

    // Random events, addresses and read data.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) == 0), $urandom, $urandom);
    end
    repeat (6) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
